xadac_scoreboard: RTL and testbench
===================================

# xadac_scoreboard

Issue scheduler for the xadac vector unit. It sits between the offload instruction decoder and the vector execution/load-store units and owns the shared vector register file (VRF) hazard state. It admits an instruction only when its source and destination vector registers are hazard-free and a transaction ID is free. It then allocates the lowest free ID and records the instruction's register usage until the execution side retires that ID.

## Interface

Parameters:
- NrVregs, default VrfLen (32): VRF entries tracked.
- NrIds, default SbLen (16): concurrent in-flight IDs.
- NrSrc, default NoVs (3): vector source operands per instruction.

Ports (reset is synchronous and active-high; one clock):
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- issue_valid_i  in  1  decoder presents an instruction
- issue_ready_o  out  1  scoreboard accepts; must not depend on issue_valid_i
- issue_vs_i  in  NrSrc*VrfIdWidth  source vreg indices, operand k at bits [k*5 +: 5]
- issue_vs_en_i  in  NrSrc  per-source enable
- issue_vd_i  in  VrfIdWidth  destination vreg
- issue_vd_en_i  in  1  destination enable
- issue_id_o  out  IdWidth  ID allocated on handshake; the lowest free ID
- retire_valid_i  in  1  execution side retires an ID; no ready, always accepted
- retire_id_i  in  IdWidth  ID being retired
- flush_i  in  1  discard all in-flight entries
- inflight_o  out  IdWidth+1  registered count of valid entries, 0..NrIds
- idle_o  out  1  inflight_o == 0

## Operation

- State per ID: valid bit, rmask (NrVregs bits), wmask (NrVregs bits). No other state apart from the inflight counter.
- Busy vectors, combinational:
  - rbusy[r] = OR over IDs of valid & rmask[r]
  - wbusy[r] = OR over IDs of valid & wmask[r]
- Hazard-free when all of these hold:
  - no enabled source has wbusy (RAW)
  - if vd enabled, !wbusy[vd] (WAW) and !rbusy[vd] (WAR)
- An instruction's own sources equal to its vd are not hazards. Duplicate sources collapse into the mask.
- issue_ready_o = !rst_i & hazard-free & any ID free.
- On handshake:
  - entry[issue_id_o] gets valid=1
  - rmask = one-hot OR of the enabled sources
  - wmask = one-hot vd if enabled, else 0
- Retire of a valid ID clears its valid bit. Retire of an already-invalid ID is ignored with no state change.
- Out-of-order retire is legal.
- flush_i clears all valid bits and the counter next cycle, overriding issue and retire in the same cycle. issue_ready_o is not gated by flush.
- inflight_o update: +1 on handshake, -1 on a valid retire; both in the same cycle leaves it unchanged.
- Mid-operation rst_i: all entries invalid next cycle and issue_ready_o=0 while rst_i is high.

## Timing

- Reset values:
  - all valid=0, masks=0, inflight_o=0, idle_o=1
  - issue_id_o=0
  - issue_ready_o=0 while rst_i is high, then 1 for any hazard-free instruction
- Issue and retire update state at the clock edge; the effects are visible to hazard checks in the following cycle.
- Same cycle as a retire (without bypass): the retiring ID is still counted busy and not free. Earliest re-issue against a retired register is one cycle after the retire.
- Back-to-back independent issues: one per cycle until all NrIds IDs are allocated.

## Configuration

- XADAC_SB_BYPASS_EN defined:
  - the retiring ID (if valid) is excluded from rbusy, wbusy and the free check in the same cycle
  - an instruction blocked only by that ID issues in the retire cycle
  - the allocator may hand out the retiring ID; allocation write wins over clear for that entry, and inflight_o stays unchanged
- XADAC_SB_BYPASS_EN undefined: the behaviour in Timing applies, with no combinational path from retire_* to issue_ready_o or issue_id_o.

## Structure

- xadac_pkg gains:
  - sb_entry_t: valid, rmask, wmask
  - SbCntWidth = IdWidth+1
- The block reuses the existing IdT, VrfIdT, SbLen, VrfLen and NoVs.
- One sub-module, xadac_sb_alloc: a lowest-set-bit priority encoder over the free vector that outputs the ID and an any-free flag.

## Test plan

- Reset, then an instruction with vs={1,2}, vd=3 and issue_valid_i=1: handshake in the first cycle, issue_id_o=0, inflight_o=1 next cycle.
- RAW: issue vd=5, then an instruction with vs=5. Ready stays 0 until retire of ID 0. Ready rises one cycle after the retire, or in the retire cycle with XADAC_SB_BYPASS_EN.
- WAR/WAW: with ID 0 reading v7 in flight, an instruction with vd=7 is blocked. After retire(0), it issues with issue_id_o=0.
- Full: issue 16 independent instructions. Ready then drops with inflight_o=16. Retire ID 9 and the next issue gets issue_id_o=9.
- Retire of an invalid ID 4 with nothing in flight: no change, inflight_o stays 0.
- Flush with 3 in flight plus a simultaneous handshake and retire: inflight_o=0 and idle_o=1 next cycle, all vregs free.

Source files
------------

// File: rtl/xadac_pkg.sv
// Shared types and sizing for the xadac vector unit.
package xadac_pkg;

    localparam int unsigned VrfLen     = 32;
    localparam int unsigned SbLen      = 16;
    localparam int unsigned NoVs       = 3;
    localparam int unsigned VrfIdWidth = $clog2(VrfLen);
    localparam int unsigned IdWidth    = $clog2(SbLen);
    localparam int unsigned SbCntWidth = IdWidth + 1;

    typedef logic [IdWidth-1:0]    IdT;
    typedef logic [VrfIdWidth-1:0] VrfIdT;

    typedef struct packed {
        logic              valid;
        logic [VrfLen-1:0] rmask;
        logic [VrfLen-1:0] wmask;
    } sb_entry_t;

endpackage

// File: rtl/xadac_sb_alloc.sv
// Lowest-free-ID allocator for the scoreboard: priority encoder plus any-free flag.
module xadac_sb_alloc
    import xadac_pkg::*;
#(
    parameter  int unsigned NrIds = SbLen,
    localparam int unsigned IW    = $clog2(NrIds)
) (
    input  logic [NrIds-1:0] free_i,
    output logic [IW-1:0]    id_o,
    output logic             any_o
);

    always_comb begin
        id_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NrIds - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                id_o = IW'(i);
            end
        end
    end

    assign any_o = |free_i;

endmodule

// File: rtl/xadac_scoreboard.sv
// VRF hazard scoreboard and ID allocator for the xadac vector unit.
// Define XADAC_SB_BYPASS_EN to let a same-cycle retire free its ID and registers for issue.
module xadac_scoreboard
    import xadac_pkg::*;
#(
    parameter  int unsigned NrVregs = VrfLen,
    parameter  int unsigned NrIds   = SbLen,
    parameter  int unsigned NrSrc   = NoVs,
    localparam int unsigned VW      = $clog2(NrVregs),
    localparam int unsigned IW      = $clog2(NrIds)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [NrSrc*VW-1:0] issue_vs_i,
    input  logic [NrSrc-1:0]    issue_vs_en_i,
    input  logic [VW-1:0]       issue_vd_i,
    input  logic                issue_vd_en_i,
    output logic [IW-1:0]       issue_id_o,
    input  logic                retire_valid_i,
    input  logic [IW-1:0]       retire_id_i,
    input  logic                flush_i,
    output logic [IW:0]         inflight_o,
    output logic                idle_o
);

    sb_entry_t entries_q [NrIds];
    sb_entry_t entries_d [NrIds];
    logic [IW:0] inflight_q, inflight_d;

    logic [NrIds-1:0]   valid, retiring, active;
    logic [NrVregs-1:0] rbusy, wbusy, req_rmask, req_wmask;
    logic               retire_hit, hazard, any_free, handshake;
    logic [IW-1:0]      alloc_id;

    always_comb begin
        for (int i = 0; i < NrIds; i++) begin
            valid[i]    = entries_q[i].valid;
            retiring[i] = retire_valid_i && (retire_id_i == IW'(i)) && entries_q[i].valid;
        end
    end

    assign retire_hit = |retiring;

`ifdef XADAC_SB_BYPASS_EN
    assign active = valid & ~retiring;
`else
    assign active = valid;
`endif

    always_comb begin
        rbusy = '0;
        wbusy = '0;
        for (int i = 0; i < NrIds; i++) begin
            if (active[i]) begin
                rbusy = rbusy | entries_q[i].rmask[NrVregs-1:0];
                wbusy = wbusy | entries_q[i].wmask[NrVregs-1:0];
            end
        end
    end

    always_comb begin
        req_rmask = '0;
        req_wmask = '0;
        for (int k = 0; k < NrSrc; k++) begin
            if (issue_vs_en_i[k]) begin
                req_rmask[issue_vs_i[k*VW +: VW]] = 1'b1;
            end
        end
        if (issue_vd_en_i) begin
            req_wmask[issue_vd_i] = 1'b1;
        end
    end

    // Only in-flight state is compared, so an instruction's own vs == vd never blocks it.
    assign hazard = (|(req_rmask & wbusy)) | (|(req_wmask & (wbusy | rbusy)));

    xadac_sb_alloc #(
        .NrIds (NrIds)
    ) u_alloc (
        .free_i (~active),
        .id_o   (alloc_id),
        .any_o  (any_free)
    );

    assign issue_ready_o = !rst_i && !hazard && any_free;
    assign issue_id_o    = alloc_id;
    assign handshake     = issue_valid_i && issue_ready_o;

    always_comb begin
        for (int i = 0; i < NrIds; i++) begin
            entries_d[i] = entries_q[i];
        end
        inflight_d = inflight_q;
        if (flush_i) begin
            for (int i = 0; i < NrIds; i++) begin
                entries_d[i] = '0;
            end
            inflight_d = '0;
        end else begin
            for (int i = 0; i < NrIds; i++) begin
                if (retiring[i]) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            // Allocation after clear: a bypassed re-allocation of the retiring ID wins.
            if (handshake) begin
                entries_d[alloc_id].valid = 1'b1;
                entries_d[alloc_id].rmask = VrfLen'(req_rmask);
                entries_d[alloc_id].wmask = VrfLen'(req_wmask);
            end
            inflight_d = inflight_q + (IW+1)'(handshake) - (IW+1)'(retire_hit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrIds; i++) begin
                entries_q[i] <= '0;
            end
            inflight_q <= '0;
        end else begin
            for (int i = 0; i < NrIds; i++) begin
                entries_q[i] <= entries_d[i];
            end
            inflight_q <= inflight_d;
        end
    end

    assign inflight_o = inflight_q;
    assign idle_o     = (inflight_q == '0);

endmodule

// File: tb/tb_xadac_scoreboard.sv
// Directed plus randomized bench for xadac_scoreboard against an instruction-level hazard model.
module tb_xadac_scoreboard;

    logic        clk = 1'b0;
    logic        issue_ready, idle;
    logic [3:0]  issue_id;
    logic [4:0]  inflight;
    logic [14:0] vs_bus;

    bit       rs, iv, vden, rv, fl;
    int       vs [3];
    bit [2:0] vsen;
    int       vd, rid;

    int checks = 0;
    int errors = 0;

    // Model: per ID, whether in flight and the instruction's operand lists.
    bit mvalid [16];
    int msrc   [16][3];
    bit msen   [16][3];
    int mvd    [16];
    bit mvden  [16];

    always #5 clk = ~clk;

    always_comb vs_bus = {5'(vs[2]), 5'(vs[1]), 5'(vs[0])};

    xadac_scoreboard dut (
        .clk_i          (clk),
        .rst_i          (rs),
        .issue_valid_i  (iv),
        .issue_ready_o  (issue_ready),
        .issue_vs_i     (vs_bus),
        .issue_vs_en_i  (vsen),
        .issue_vd_i     (5'(vd)),
        .issue_vd_en_i  (vden),
        .issue_id_o     (issue_id),
        .retire_valid_i (rv),
        .retire_id_i    (4'(rid)),
        .flush_i        (fl),
        .inflight_o     (inflight),
        .idle_o         (idle)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(int id);
        bit b;
        b = mvalid[id];
`ifdef XADAC_SB_BYPASS_EN
        if (rv && rid == id) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit m_conflict(int id);
        for (int k = 0; k < 3; k++) begin
            if (vsen[k] && mvden[id] && mvd[id] == vs[k]) return 1'b1;  // RAW
        end
        if (vden) begin
            if (mvden[id] && mvd[id] == vd) return 1'b1;                 // WAW
            for (int k = 0; k < 3; k++) begin
                if (msen[id][k] && msrc[id][k] == vd) return 1'b1;       // WAR
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        bit anyfree;
        anyfree = 1'b0;
        if (rs) return 1'b0;
        for (int id = 0; id < 16; id++) begin
            if (!m_busy(id)) anyfree = 1'b1;
            else if (m_conflict(id)) return 1'b0;
        end
        return anyfree;
    endfunction

    function automatic int m_id();
        for (int id = 0; id < 16; id++) begin
            if (!m_busy(id)) return id;
        end
        return 0;
    endfunction

    function automatic int m_count();
        int n;
        n = 0;
        for (int id = 0; id < 16; id++) n += int'(mvalid[id]);
        return n;
    endfunction

    task automatic m_clock(bit hs, int aid);
        if (rs || fl) begin
            for (int id = 0; id < 16; id++) mvalid[id] = 1'b0;
        end else begin
            if (rv && mvalid[rid]) mvalid[rid] = 1'b0;
            if (hs) begin
                mvalid[aid] = 1'b1;
                mvd[aid]    = vd;
                mvden[aid]  = vden;
                for (int k = 0; k < 3; k++) begin
                    msrc[aid][k] = vs[k];
                    msen[aid][k] = vsen[k];
                end
            end
        end
    endtask

    task automatic drive(bit v, int s0, int s1, int s2, bit [2:0] sen, int d, bit den,
                         bit r, int ri, bit f);
        iv = v; vs[0] = s0; vs[1] = s1; vs[2] = s2; vsen = sen;
        vd = d; vden = den; rv = r; rid = ri; fl = f;
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Compare all outputs against the model mid-cycle, then advance one clock.
    task automatic step(string tag);
        bit er;
        int eid;
        #2;
        er  = m_ready();
        eid = m_id();
        chk({tag, "/ready"}, 32'(issue_ready), 32'(er));
        if (er) chk({tag, "/id"}, 32'(issue_id), 32'(eid));
        chk({tag, "/inflight"}, 32'(inflight), 32'(m_count()));
        chk({tag, "/idle"}, 32'(idle), 32'(m_count() == 0));
        @(posedge clk);
        m_clock(iv && er, eid);
        @(negedge clk);
    endtask

    task automatic retire_all(string tag);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b1, i, 1'b0);
            step(tag);
        end
        nop();
    endtask

    initial begin
        int pick [$];
        rs = 1'b1;
        nop();
        @(negedge clk);
        step("rst0");
        step("rst1");
        rs = 1'b0;

        // First instruction after reset
        drive(1'b1, 1, 2, 0, 3'b011, 3, 1'b1, 1'b0, 0, 1'b0);
        #1 chk("first/ready", 32'(issue_ready), 32'd1);
        chk("first/id", 32'(issue_id), 32'd0);
        step("first");
        nop();
        step("first_after");
        chk("first/inflight1", 32'(inflight), 32'd1);
        retire_all("first_clean");

        // RAW
        drive(1'b1, 0, 0, 0, 3'b000, 5, 1'b1, 1'b0, 0, 1'b0);
        step("raw_prod");
        drive(1'b1, 5, 0, 0, 3'b001, 6, 1'b1, 1'b0, 0, 1'b0);
        step("raw_blk0");
        step("raw_blk1");
        rv = 1'b1; rid = 0;
        step("raw_ret");
        rv = 1'b0;
        step("raw_after");
        retire_all("raw_clean");

        // WAR / WAW
        drive(1'b1, 7, 0, 0, 3'b001, 0, 1'b0, 1'b0, 0, 1'b0);
        step("war_rd");
        drive(1'b1, 0, 0, 0, 3'b000, 7, 1'b1, 1'b0, 0, 1'b0);
        step("war_blk");
        drive(1'b0, 0, 0, 0, 3'b000, 7, 1'b1, 1'b1, 0, 1'b0);
        step("war_ret");
        drive(1'b1, 0, 0, 0, 3'b000, 7, 1'b1, 1'b0, 0, 1'b0);
        #1 chk("war/id0", 32'(issue_id), 32'd0);
        step("war_iss");
        retire_all("war_clean");

        // Fill all IDs
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 0, 0, 0, 3'b000, 16 + i, 1'b1, 1'b0, 0, 1'b0);
            step("full_fill");
        end
        drive(1'b1, 0, 0, 0, 3'b000, 1, 1'b1, 1'b0, 0, 1'b0);
        #1 chk("full/inflight16", 32'(inflight), 32'd16);
        chk("full/ready0", 32'(issue_ready), 32'd0);
        step("full_blk");
        drive(1'b0, 0, 0, 0, 3'b000, 1, 1'b1, 1'b1, 9, 1'b0);
        step("full_ret9");
        drive(1'b1, 0, 0, 0, 3'b000, 1, 1'b1, 1'b0, 0, 1'b0);
        #1 chk("full/id9", 32'(issue_id), 32'd9);
        step("full_reissue");
        retire_all("full_clean");

        // Retire of an invalid ID
        drive(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b1, 4, 1'b0);
        step("inv_ret");
        nop();
        step("inv_after");
        chk("inv/inflight0", 32'(inflight), 32'd0);

        // Flush with simultaneous handshake and retire
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 0, 0, 0, 3'b000, i, 1'b1, 1'b0, 0, 1'b0);
            step("flush_fill");
        end
        drive(1'b1, 0, 0, 0, 3'b000, 10, 1'b1, 1'b1, 0, 1'b1);
        step("flush");
        drive(1'b1, 1, 3, 0, 3'b011, 2, 1'b1, 1'b0, 0, 1'b0);
        #1 chk("flush/inflight0", 32'(inflight), 32'd0);
        chk("flush/idle1", 32'(idle), 32'd1);
        chk("flush/ready1", 32'(issue_ready), 32'd1);
        step("flush_after");

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 500; c++) begin
            pick.delete();
            for (int id = 0; id < 16; id++) if (mvalid[id]) pick.push_back(id);
            iv   = ($urandom_range(9) < 7);
            for (int k = 0; k < 3; k++) vs[k] = $urandom_range(7);
            vsen = 3'($urandom);
            vd   = $urandom_range(7);
            vden = ($urandom_range(3) != 0);
            rv   = ($urandom_range(9) < 4);
            if (pick.size() > 0 && $urandom_range(3) != 0)
                rid = pick[$urandom_range(pick.size() - 1)];
            else
                rid = $urandom_range(15);
            fl = ($urandom_range(99) < 2);
            rs = ($urandom_range(199) == 0);
            step("rand");
        end
        rs = 1'b0;
        nop();
        step("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
